// File: rtl/secret_stim_check.sv
// Stimulus/response checker for the protected accumulator and pass-through block.
// Drives LFSR stimulus, models the 1-cycle accumulator, and counts mismatches.
module secret_stim_check #(
  parameter int unsigned NUM_CYCLES = 64,
  parameter logic [31:0] SEED       = 32'hACE1_2019
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [31:0]  accum_in,
  input  logic [31:0]  accum_out,
  output logic [301:0] pt_drv,
  input  logic [301:0] pt_ret,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [15:0]  first_err_cyc
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [15:0] LAST_IDX = 16'(NUM_CYCLES - 1);
  localparam logic [15:0] NO_ERR   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] exp_acc;
  logic [15:0] idx;

  logic [31:0] lfsr_nxt;
  logic        acc_err;
  logic        pt_err;
  logic        cyc_err;
  logic [16:0] err_sum;
  logic [15:0] err_count_nxt;

  // Lower 302 bits of the LFSR word repeated ten times.
  function automatic logic [301:0] spread(input logic [31:0] v);
    logic [301:0] r;
    r = '0;
    for (int i = 0; i < 302; i++) begin
      r[i] = v[i[4:0]];
    end
    return r;
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    lfsr_nxt      = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
    acc_err       = ((state == S_RUN) || (state == S_CHECK)) && (accum_out != exp_acc);
    pt_err        = (state == S_RUN) && (pt_ret != pt_drv);
    cyc_err       = acc_err | pt_err;
    err_sum       = {1'b0, err_count} + 17'(acc_err) + 17'(pt_err);
    err_count_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      accum_in      <= '0;
      pt_drv        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_cyc <= NO_ERR;
      lfsr          <= SEED_EFF;
      exp_acc       <= '0;
      idx           <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_ARM;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end

        // The accumulator has no reset, so its present value becomes the base.
        S_ARM: begin
          exp_acc       <= accum_out;
          lfsr          <= SEED_EFF;
          err_count     <= '0;
          first_err_cyc <= NO_ERR;
          idx           <= '0;
          accum_in      <= SEED_EFF;
          pt_drv        <= spread(SEED_EFF);
          state         <= S_RUN;
        end

        S_RUN: begin
          err_count <= err_count_nxt;
          if (cyc_err && (err_count == 16'd0)) begin
            first_err_cyc <= idx;
          end
          exp_acc <= exp_acc + accum_in;
          lfsr    <= lfsr_nxt;
          idx     <= idx + 16'd1;
          if (idx == LAST_IDX) begin
            state    <= S_CHECK;
            accum_in <= '0;
          end else begin
            accum_in <= lfsr_nxt;
            pt_drv   <= spread(lfsr_nxt);
          end
        end

        // Only the accumulator is compared here; it still owes the last addition.
        S_CHECK: begin
          err_count <= err_count_nxt;
          if (cyc_err && (err_count == 16'd0)) begin
            first_err_cyc <= idx;
          end
          pt_drv <= '0;
          busy   <= 1'b0;
          done   <= 1'b1;
          pass   <= (err_count_nxt == 16'd0);
          state  <= S_DONE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secret_stim_check.sv
// Bench for secret_stim_check: hosts a model of the protected block, a scoreboard
// derived from the accumulate/pass-through rules, and directed scenarios.
module tb_secret_stim_check;

  localparam int          N    = 64;
  localparam logic [31:0] SEED = 32'hACE1_2019;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  accum_in;
  logic [31:0]  accum_out;
  logic [301:0] pt_drv;
  logic [301:0] pt_ret;
  logic         busy, done, pass;
  logic [15:0]  err_count, first_err_cyc;

  logic         start_s = 1'b0;
  logic [31:0]  accum_in_s;
  logic [31:0]  accum_out_s;
  logic [301:0] pt_drv_s;
  logic [301:0] pt_ret_s;
  logic         busy_s, done_s, pass_s;
  logic [15:0]  err_count_s, first_err_cyc_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  secret_stim_check #(.NUM_CYCLES(N), .SEED(SEED)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .accum_in(accum_in), .accum_out(accum_out),
    .pt_drv(pt_drv), .pt_ret(pt_ret),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_cyc(first_err_cyc)
  );

  secret_stim_check #(.NUM_CYCLES(1), .SEED(SEED)) u_dut_short (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .accum_in(accum_in_s), .accum_out(accum_out_s),
    .pt_drv(pt_drv_s), .pt_ret(pt_ret_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_count_s), .first_err_cyc(first_err_cyc_s)
  );

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  function automatic logic [301:0] rep(input logic [31:0] v);
    logic [301:0] r;
    for (int i = 0; i < 302; i++) r[i] = v[i % 32];
    return r;
  endfunction

  // Protected-block stand-in: 1-cycle accumulator without reset, combinational pass-through.
  logic [31:0] acc = 32'd0;
  logic [31:0] acc_s = 32'd0;
  logic        preload = 1'b0;
  logic [31:0] preload_val = 32'd0;
  logic        stuck = 1'b0;
  logic        pt_fault = 1'b0;

  // Scoreboard state: m_pos 0 = idle/done, 1 = arm, 2..N+1 = run index m_pos-2, N+2 = check.
  int          m_pos = 0;
  logic        m_done = 1'b0;
  logic        m_pass = 1'b0;
  logic        m_seen = 1'b0;
  logic [15:0] m_err = 16'd0;
  logic [15:0] m_first = 16'hFFFF;
  logic [31:0] m_sum = 32'd0;
  logic [31:0] seq [0:N-1];

  always @(posedge clk) begin
    if (preload) acc <= preload_val;
    else if (!stuck) acc <= acc + accum_in;
    acc_s <= acc_s + accum_in_s;
  end

  assign accum_out   = acc;
  assign pt_ret      = pt_drv ^ ((pt_fault && (m_pos == 7)) ? 302'd1 : 302'd0);
  assign accum_out_s = acc_s;
  assign pt_ret_s    = pt_drv_s;

  always @(posedge clk or negedge rst_n) begin : model
    int e;
    int k;
    int tot;
    e = 0;
    k = 0;
    tot = 0;
    if (!rst_n) begin
      m_pos   <= 0;
      m_done  <= 1'b0;
      m_pass  <= 1'b0;
      m_err   <= 16'd0;
      m_first <= 16'hFFFF;
      m_seen  <= 1'b0;
    end else if (m_pos == 0) begin
      if (start) begin
        m_pos  <= 1;
        m_done <= 1'b0;
        m_pass <= 1'b0;
      end
    end else if (m_pos == 1) begin
      m_pos   <= 2;
      m_sum   <= accum_out;
      m_err   <= 16'd0;
      m_first <= 16'hFFFF;
      m_seen  <= 1'b0;
    end else begin
      k = m_pos - 2;
      if (accum_out != m_sum) e++;
      if (k < N) begin
        if (pt_ret != rep(seq[k])) e++;
        m_sum <= m_sum + seq[k];
        m_pos <= m_pos + 1;
      end else begin
        m_pos  <= 0;
        m_done <= 1'b1;
      end
      tot = int'(m_err) + e;
      if (tot > 65535) tot = 65535;
      m_err <= 16'(tot);
      if (e != 0 && !m_seen) begin
        m_first <= 16'(k);
        m_seen  <= 1'b1;
      end
      if (k == N) m_pass <= (tot == 0);
    end
  end

  always @(negedge clk) begin : scoreboard
    logic [31:0]  e_ai;
    logic [301:0] e_pt;
    e_ai = 32'd0;
    e_pt = '0;
    if (m_pos >= 2 && m_pos <= N + 1) begin
      e_ai = seq[m_pos-2];
      e_pt = rep(seq[m_pos-2]);
    end else if (m_pos == N + 2) begin
      e_pt = rep(seq[N-1]);
    end
    check("cyc_accum_in", accum_in, e_ai);
    check("cyc_pt_drv", pt_drv, e_pt);
    check("cyc_busy", busy, m_pos != 0);
    check("cyc_done", done, m_done);
    check("cyc_pass", pass, m_pass);
    check("cyc_err_count", err_count, m_err);
    check("cyc_first_err", first_err_cyc, m_first);
  end

  // Called on a negedge; returns on the first negedge with done high or after a bound.
  task automatic run_test(input bit lit, output int busy_cycles);
    busy_cycles = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      if (busy) busy_cycles++;
      if (lit && i == 1) begin
        check("lit_accum_in_idx0", accum_in, 32'hACE1_2019);
        check("lit_pt_drv_lo_idx0", pt_drv[31:0], 32'hACE1_2019);
        check("lit_pt_drv_hi_idx0", pt_drv[301:288], 14'h2019);
      end
      if (lit && i == 2) check("lit_accum_in_idx1", accum_in, 32'hD650_900F);
      @(negedge clk);
    end
  endtask

  task automatic expect_result(input string tag, input int bc, input bit e_pass,
                               input logic [15:0] e_err, input logic [15:0] e_first);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_cycles"}, bc, N + 2);
    check({tag, "_pass"}, pass, e_pass);
    check({tag, "_err_count"}, err_count, e_err);
    check({tag, "_first_err"}, first_err_cyc, e_first);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bc;
    int run_len;
    int dones;
    seq[0] = SEED;
    for (int k = 1; k < N; k++) seq[k] = lfsr_step(seq[k-1]);

    preload = 1'b1;
    preload_val = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_accum_in", accum_in, 32'd0);
    check("rst_pt_drv", pt_drv, 302'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    check("rst_first_err", first_err_cyc, 16'hFFFF);
    rst_n = 1'b1;
    @(negedge clk);
    preload = 1'b0;

    run_test(1'b1, bc);
    expect_result("base", bc, 1'b1, 16'd0, 16'hFFFF);

    preload = 1'b1;
    preload_val = 32'h1234_5678;
    @(negedge clk);
    preload = 1'b0;
    run_test(1'b0, bc);
    expect_result("rebase", bc, 1'b1, 16'd0, 16'hFFFF);

    pt_fault = 1'b1;
    run_test(1'b0, bc);
    pt_fault = 1'b0;
    expect_result("pt_flip", bc, 1'b0, 16'd1, 16'd5);

    stuck = 1'b1;
    run_test(1'b0, bc);
    stuck = 1'b0;
    expect_result("stuck", bc, 1'b0, 16'd64, 16'd1);

    // Abort at RUN index 10 after a planted error, then restart cleanly.
    pt_fault = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("abort_err_before", err_count, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_accum_in", accum_in, 32'd0);
    check("abort_pt_drv", pt_drv, 302'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_err_count", err_count, 16'd0);
    check("abort_first_err", first_err_cyc, 16'hFFFF);
    pt_fault = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(1'b0, bc);
    expect_result("restart", bc, 1'b1, 16'd0, 16'hFFFF);

    // One-cycle runs with start held: ARM, RUN, CHECK, DONE repeating.
    run_len = 0;
    dones = 0;
    start_s = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy_s) run_len++;
      if (done_s) begin
        dones++;
        check("short_run_len", run_len, 3);
        check("short_pass", pass_s, 1'b1);
        check("short_err_count", err_count_s, 16'd0);
        run_len = 0;
      end
    end
    start_s = 1'b0;
    check("short_done_count", dones, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
